round_robin_fifo_dispatcher: RTL
================================

Name: round_robin_fifo_dispatcher

Overview:
Single-producer to four-consumer dispatcher. It is the mirror of the round-robin FIFO arbiter.
- One write stream is distributed in strict round-robin order (a, b, c, d, a, ...) into four internal FIFOs.
- Each FIFO is drained independently by its own read enable.
- It sits downstream of a single-stream producer and feeds four per-channel consumers.

Parameters:
WIDTH, 8, data width of din and of each channel output
DEPTH, 8, entries per channel FIFO (power of two, >= 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
wen  input  1  write strobe; din is offered this cycle
din  input  WIDTH  write data
ren  input  4  per-channel read enables; bit0=a, bit1=b, bit2=c, bit3=d
a  output  WIDTH  channel a read data (registered)
b  output  WIDTH  channel b read data (registered)
c  output  WIDTH  channel c read data (registered)
d  output  WIDTH  channel d read data (registered)
valid  output  4  bit i high for one cycle when channel i output carries data
full  output  4  bit i high when FIFO i holds DEPTH entries (combinational from count)
empty  output  4  bit i high when FIFO i holds 0 entries (combinational from count)
drop  output  1  one-cycle pulse: the write offered last cycle was rejected

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - turn=0 (channel a); all read/write pointers and counts cleared.
  - a, b, c, d = 0; valid=0; drop=0; full=0000; empty=1111.
  - Memory contents are not cleared.
- Turn pointer: 2-bit register selecting the target FIFO for the next write.
- Write at a rising edge with wen=1:
  - Target not full (evaluated on pre-edge count): din is stored at the tail of FIFO[turn]; turn <= turn+1 mod 4 (3 wraps to 0).
  - Target full: din is discarded, turn holds, drop=1 for the following cycle.
  - wen=0: turn holds, drop=0.
- Read for each channel i, at a rising edge:
  - ren[i]=1 and FIFO i not empty (pre-edge): head word appears on the channel output after the edge; valid[i]=1; head advances.
  - ren[i]=1 and FIFO i empty: output=0, valid[i]=0.
  - ren[i]=0: output=0, valid[i]=0.
  - Outputs are zero whenever valid is low; there is no hold of stale data.
- Latency:
  - A word written at edge N is readable by a read at edge N+1 and appears on the output after edge N+1.
  - Read data is valid one cycle after the read edge.
- Simultaneous events on the same FIFO in one cycle:
  - Read+write, not full and not empty: both happen; count unchanged.
  - Read+write, FIFO full: write is dropped (full is pre-edge); read proceeds; count becomes DEPTH-1.
  - Read+write, FIFO empty: read returns valid=0; write is stored; count becomes 1.
- Reads on all four channels may occur in the same cycle.
- Pointers wrap modulo DEPTH. Count range is 0..DEPTH, width log2(DEPTH)+1.
- Reset mid-operation discards all buffered data and any in-flight output immediately.

Test Plan:
1. Reset, then wen=1 with din=87, 56, 9, 13 on 4 consecutive edges; next edge ren=1111 -> a=87, b=56, c=9, d=13, valid=1111; then empty=1111.
2. After scenario 1, write din=85 (turn wrapped) -> stored in a; ren=0001 -> a=85, valid=0001; ren=0001 again -> a=0, valid=0000.
3. From reset, 32 writes of din=0..31 with no reads -> full=1111, drop never set; a 33rd write of din=200 -> drop=1 for one cycle, turn stays 0; 8 reads of a -> 0, 4, 8, ..., 28, then empty[0]=1.
4. FIFO a full (values 0, 4, ..., 28) with turn=0; same edge wen=1, din=99, ren=0001 -> a=0, valid[0]=1, drop=1, full[0]=0, count=7; 99 is never read.
5. Write 3 words; one edge with wen=1, din=77 and ren=1000 while d is empty -> valid[3]=0, d=0; next read of d -> 77.
6. Write 3 words, then drop rst_n mid-cycle with ren=0001 pending -> valid=0000, a=0, empty=1111, turn=0 before the next edge; after release, the first write lands in a.

Source files
------------

// File: rtl/round_robin_fifo_dispatcher.sv
// Generic single-clock FIFO with a registered, zero-when-idle read port.
// Latency: a word written at edge N can be read at edge N+1 and is on rd_dat after that edge.
// Backpressure: writes are refused while full and reads are ignored while empty, both judged on the count before the edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             rd_vld,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = wr_vld & ~full;
    assign rd_en = rd_rdy & ~empty;

    // Storage has no reset: a cleared count makes the old contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            rd_dat <= '0;
            rd_vld <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_en) begin
                rptr <= rptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            rd_dat <= rd_en ? mem[rptr] : '0;
            rd_vld <= rd_en;
        end
    end
endmodule

// Spreads one write stream over four FIFOs in strict a,b,c,d order; each FIFO drains on its own ren bit.
// Latency: write at edge N is readable at edge N+1; read data and valid appear one cycle after the read edge.
// Backpressure: a write aimed at a full FIFO is discarded, turn holds, and drop pulses the next cycle.
module round_robin_fifo_dispatcher #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    input  logic [3:0]       ren,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       valid,
    output logic [3:0]       full,
    output logic [3:0]       empty,
    output logic             drop
);
    logic [1:0]       turn;
    logic [3:0]       wr_vld;
    logic [WIDTH-1:0] rd_dat [4];

    // Only the FIFO under the turn pointer sees the write; it rejects it itself when full.
    always_comb begin
        wr_vld = '0;
        if (wen) begin
            wr_vld[turn] = 1'b1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_chan
        sync_fifo #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .wr_vld(wr_vld[i]),
            .wr_dat(din),
            .rd_rdy(ren[i]),
            .rd_dat(rd_dat[i]),
            .rd_vld(valid[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn <= 2'd0;
            drop <= 1'b0;
        end else begin
            drop <= wen & full[turn];
            if (wen && !full[turn]) begin
                turn <= turn + 2'd1;
            end
        end
    end

    assign a = rd_dat[0];
    assign b = rd_dat[1];
    assign c = rd_dat[2];
    assign d = rd_dat[3];
endmodule
